// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO; MIPS_MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic is_div, neg_q, neg_r, dz, pend;
  logic [WIDTH-1:0] d, acc, mq, abs_a, abs_b, qfix, rfix;
  logic [WIDTH:0] add, trial, sub;
  logic [2*WIDTH-1:0] prod, fprod;
  logic sg, go, mt, fast_mul;
  assign sg    = ~op[0];
  assign abs_a = (sg & a[WIDTH-1]) ? -a : a;
  assign abs_b = (sg & b[WIDTH-1]) ? -b : b;
  assign mt    = start & ~flush & (op[2:1] == 2'b10);
`ifdef MIPS_MULDIV_FAST_MUL_EN
  assign fast_mul = start & ~flush & (op[2:1] == 2'b00);
  assign fprod    = {{WIDTH{sg & a[WIDTH-1]}}, a} * {{WIDTH{sg & b[WIDTH-1]}}, b};
`else
  assign fast_mul = 1'b0;
  assign fprod    = '0;
`endif
  assign go    = start & ~flush & ((op[2:1] == 2'b01) | ((op[2:1] == 2'b00) & ~fast_mul));
  // shift-add step for multiply, restoring trial subtraction for divide
  assign add   = {1'b0, acc} + {1'b0, mq[0] ? d : '0};
  assign trial = {acc, mq[WIDTH-1]};
  assign sub   = trial - {1'b0, d};
  assign prod  = neg_q ? -{acc, mq} : {acc, mq};
  assign qfix  = neg_q ? -mq : mq;
  assign rfix  = neg_r ? -acc : acc;
  assign busy  = state != IDLE;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = go ? CALC : IDLE;
    else if (flush || state == FIX) state_nx = IDLE;
    else if (cnt == '0) state_nx = FIX;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      pend <= 1'b0;
      d <= '0;
      acc <= '0;
      mq <= '0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      pend <= 1'b0;
      if (pend) begin
        {hi, lo} <= {acc, mq};
        done <= 1'b1;
      end
      if (state == IDLE) begin
        if (go) begin
          d <= abs_b;
          mq <= abs_a;
          acc <= '0;
          cnt <= CW'(WIDTH - 1);
          is_div <= op[1];
          neg_q <= sg & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r <= sg & a[WIDTH-1];
          dz <= b == '0;
        end
        if (fast_mul) begin
          {acc, mq} <= fprod;
          pend <= 1'b1;
        end
        if (mt & op[0]) lo <= a;
        if (mt & ~op[0]) hi <= a;
      end else if (!flush) begin
        if (state == CALC) begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            acc <= sub[WIDTH] ? trial[WIDTH-1:0] : sub[WIDTH-1:0];
            mq <= {mq[WIDTH-2:0], ~sub[WIDTH]};
          end else begin
            acc <= add[WIDTH:1];
            mq <= {add[0], mq[WIDTH-1:1]};
          end
        end else begin
          if (is_div) begin
            hi <= rfix;
            lo <= dz ? '1 : qfix;
          end else {hi, lo} <= prod;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: directed vectors for the multiply/divide unit at WIDTH=32
module tb_mips_muldiv_unit;
`ifdef MIPS_MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011, MTHI = 3'b100, MTLO = 3'b101;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, flush = 1'b0, busy, done;
  logic [2:0] op = 3'b000;
  logic [31:0] a = '0, b = '0, hi, lo;
  int total = 0, passed = 0;
  mips_muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .start(start), .op(op), .flush(flush),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else passed++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    int n;
    logic bk, bw;
    bit iter;
    iter = !(FAST && o[2:1] == 2'b00);
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
    bk = busy; bw = 1'b0; n = 0;
    while (!done && n < 100) begin
      step();
      n++;
      if (n == 32) bw = busy;
    end
    check({tag, " latency"}, n, iter ? 33 : 1);
    check({tag, " busy_k"}, bk, iter);
    if (iter) check({tag, " busy_k32"}, bw, 1'b1);
    check({tag, " busy_end"}, busy, 1'b0);
  endtask
  initial begin
    int dones;
    #12;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst hi", hi, 0);
    check("rst lo", lo, 0);
    reset = 1'b1;
    step();
    run(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    check("multu_max hi", hi, 32'hFFFFFFFE);
    check("multu_max lo", lo, 32'h00000001);
    run(MULT, 32'hFFFFFFFD, 32'd7, "mult_neg");
    check("mult_neg hi", hi, 32'hFFFFFFFF);
    check("mult_neg lo", lo, 32'hFFFFFFEB);
    run(MULTU, 32'd6, 32'd7, "multu_small");
    check("multu_small hi", hi, 0);
    check("multu_small lo", lo, 32'd42);
    run(DIV, 32'hFFFFFFF9, 32'd2, "div_neg");
    check("div_neg lo", lo, 32'hFFFFFFFD);
    check("div_neg hi", hi, 32'hFFFFFFFF);
    run(DIV, 32'd100, 32'hFFFFFFF9, "div_negb");
    check("div_negb lo", lo, 32'hFFFFFFF2);
    check("div_negb hi", hi, 32'd2);
    run(DIVU, 32'd7, 32'd0, "divu_zero");
    check("divu_zero lo", lo, 32'hFFFFFFFF);
    check("divu_zero hi", hi, 32'd7);
    run(DIV, 32'hFFFFFFF9, 32'd0, "div_zero");
    check("div_zero lo", lo, 32'hFFFFFFFF);
    check("div_zero hi", hi, 32'hFFFFFFF9);
    run(DIV, 32'h80000000, 32'hFFFFFFFF, "div_min");
    check("div_min lo", lo, 32'h80000000);
    check("div_min hi", hi, 0);
    op = MTHI; a = 32'h1234; start = 1'b1;
    step();
    check("mthi hi", hi, 32'h1234);
    check("mthi done", done, 0);
    op = MTLO; a = 32'h5678;
    step();
    start = 1'b0;
    check("mtlo lo", lo, 32'h5678);
    check("mtlo hi", hi, 32'h1234);
    check("mtlo done", done, 0);
    op = FAST ? DIV : MULT; a = 32'd5; b = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    check("flush busy_pre", busy, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush busy", busy, 0);
    dones = 0;
    repeat (40) begin
      step();
      if (done) dones++;
    end
    check("flush dones", dones, 0);
    check("flush hi", hi, 32'h1234);
    check("flush lo", lo, 32'h5678);
    op = DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    dones = 0;
    repeat (4) step();
    op = MULTU; a = 32'd3; b = 32'd3; start = 1'b1;
    step();
    op = MTHI; a = 32'hABCD;
    step();
    start = 1'b0;
    repeat (60) begin
      step();
      if (done) dones++;
    end
    check("restart dones", dones, 1);
    check("restart lo", lo, 32'd14);
    check("restart hi", hi, 32'd2);
    op = MTHI; a = 32'hDEAD; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    check("flush_mt hi", hi, 32'd2);
    op = DIV; a = 32'd100; b = 32'd7; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    check("flush_start busy", busy, 0);
    op = DIV; a = 32'd100; b = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    #2 reset = 1'b0;
    #1;
    check("async busy", busy, 0);
    check("async done", done, 0);
    check("async hi", hi, 0);
    check("async lo", lo, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
